// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared FSM state type and default sizing for the sequence scan controller
// Contents: state_t (IDLE/SHIFT/DONE, encoding 3 unused), DEF_WIDTH, DEF_RUN_LEN
package seq_scan_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_RUN_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: word-in and result-out valid/ready bundle for seq_scan_ctrl
// Signals: in_valid/in_ready/in_data (word producer), out_valid/out_ready/hit_count/
// first_hit_idx/hit_any (result consumer). master = producer/consumer side, slave = controller.
interface seq_scan_ctrl_if #(
    parameter int WIDTH = seq_scan_pkg::DEF_WIDTH
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] hit_count;
    logic [IDX_W-1:0] first_hit_idx;
    logic             hit_any;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, hit_count, first_hit_idx, hit_any
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, hit_count, first_hit_idx, hit_any
    );

endinterface

// File: rtl/seq_scan_ctrl_run_len_detector.sv
// run_len_detector: flags each bit that completes a run of RUN_LEN or more identical bits
// Ports: clk, rst (async, active-high), i_clr (sync history wipe), i_en (bit strobe),
// i_bit (scanned bit), o_hit (combinational hit for the bit presented this cycle)
module run_len_detector #(
    parameter int RUN_LEN = seq_scan_pkg::DEF_RUN_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_bit,
    output logic o_hit
);
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    logic             r_last;
    logic             r_has_hist;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run;

    // Run restarts on a change or with no history; otherwise it saturates at RUN_LEN.
    assign w_run = (!r_has_hist || i_bit != r_last) ? RUN_W'(1) :
                   (r_run == RUN_W'(RUN_LEN)) ? r_run : r_run + RUN_W'(1);
    assign o_hit = i_en && (w_run >= RUN_W'(RUN_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= 1'b0;
            r_has_hist <= 1'b0;
            r_run      <= '0;
        end else if (i_clr) begin
            r_last     <= 1'b0;
            r_has_hist <= 1'b0;
            r_run      <= '0;
        end else if (i_en) begin
            r_last     <= i_bit;
            r_has_hist <= 1'b1;
            r_run      <= w_run;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts a word, scans it LSB-first through a run-length detector, reports hits
// Ports: clk, rst (async, active-high), i_clear (sync abort), bus (seq_scan_ctrl_if.slave:
// word in / result out handshakes), o_busy (high while shifting).
// Build option: SEQ_SCAN_CARRY_EN keeps detector history across words; default scans each word alone.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RUN_LEN = DEF_RUN_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clear,
    seq_scan_ctrl_if.slave bus,
    output logic           o_busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_bit_idx;
    logic [IDX_W-1:0] r_first_idx;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_hit_any;
    logic             w_accept;
    logic             w_shift_en;
    logic             w_last_bit;
    logic             w_det_clr;
    logic             w_hit;

    assign w_accept   = (r_state == ST_IDLE) && bus.in_valid && !i_clear;
    assign w_shift_en = (r_state == ST_SHIFT) && !i_clear;
    assign w_last_bit = r_bit_idx == IDX_W'(WIDTH - 1);

`ifdef SEQ_SCAN_CARRY_EN
    assign w_det_clr = i_clear;
`else
    assign w_det_clr = i_clear || w_accept;
`endif

    run_len_detector #(.RUN_LEN(RUN_LEN)) u_det (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_det_clr),
        .i_en  (w_shift_en),
        .i_bit (r_shift[0]),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = ST_IDLE;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        o_busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next       = bus.in_valid ? ST_SHIFT : ST_IDLE;
                bus.in_ready = !i_clear;
            end
            ST_SHIFT: begin
                w_next = w_last_bit ? ST_DONE : ST_SHIFT;
                o_busy = 1'b1;
            end
            ST_DONE: begin
                w_next        = bus.out_ready ? ST_IDLE : ST_DONE;
                bus.out_valid = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
        if (i_clear) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_hit_count <= '0;
            r_first_idx <= '0;
            r_hit_any   <= 1'b0;
        end else if (i_clear) begin
            r_bit_idx   <= '0;
            r_hit_count <= '0;
            r_first_idx <= '0;
            r_hit_any   <= 1'b0;
        end else if (w_accept) begin
            r_shift     <= bus.in_data;
            r_bit_idx   <= '0;
            r_hit_count <= '0;
            r_first_idx <= '0;
            r_hit_any   <= 1'b0;
        end else if (w_shift_en) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + IDX_W'(1);
            if (w_hit) begin
                r_hit_count <= r_hit_count + CNT_W'(1);
                if (!r_hit_any) begin
                    r_first_idx <= r_bit_idx;
                    r_hit_any   <= 1'b1;
                end
            end
        end
    end

    assign bus.hit_count     = r_hit_count;
    assign bus.first_hit_idx = r_first_idx;
    assign bus.hit_any       = r_hit_any;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: randomized and directed checks of seq_scan_ctrl against a bit-history model
module tb_seq_scan_ctrl;
    localparam int W   = 8;
    localparam int RUN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   hist[$];

    seq_scan_ctrl_if #(.WIDTH(W)) bus ();

    seq_scan_ctrl #(.WIDTH(W), .RUN_LEN(RUN)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .bus     (bus),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hit_count"}, bus.hit_count, 0);
        chk({tag, "_first_idx"}, bus.first_hit_idx, 0);
        chk({tag, "_hit_any"}, bus.hit_any, 0);
    endtask

    // Bit stream model: a bit is a hit when it and the RUN-1 bits before it
    // (within the current history) are all equal.
    task automatic model_word(input logic [W-1:0] d, output int c, output int idx, output bit a);
`ifndef SEQ_SCAN_CARRY_EN
        hist.delete();
`endif
        c = 0; idx = 0; a = 0;
        for (int i = 0; i < W; i++) begin
            bit run;
            hist.push_back(d[i]);
            if (hist.size() > RUN) void'(hist.pop_front());
            run = hist.size() == RUN;
            for (int k = 0; k < hist.size(); k++) if (hist[k] != d[i]) run = 0;
            if (run) begin
                if (!a) idx = i;
                a = 1;
                c++;
            end
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input int hold, input bit noise);
        int c, idx, cyc;
        bit a;
        model_word(d, c, idx, a);
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            chk("in_ready_shift", bus.in_ready, 0);
            if (noise) begin
                bus.out_ready = 1'($urandom);
                bus.in_valid  = 1'($urandom);
                bus.in_data   = W'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("latency", cyc, W);
        if (!bus.out_valid) return;
        chk("hit_count", bus.hit_count, c);
        chk("first_hit_idx", bus.first_hit_idx, idx);
        chk("hit_any", bus.hit_any, a);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_hit_count", bus.hit_count, c);
            chk("hold_first_idx", bus.first_hit_idx, idx);
            chk("hold_hit_any", bus.hit_any, a);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("released_out_valid", bus.out_valid, 0);
        chk("released_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        send_word(8'hFF, 0, 0);
        send_word(8'h0F, 0, 0);
        send_word(8'h55, 0, 0);
        send_word(8'hF0, 5, 0);

        // Abort in the 4th shift cycle; clear also blocks a simultaneous in_valid in IDLE.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        chk("clear_busy", busy, 0);
        chk("clear_out_valid", bus.out_valid, 0);
        chk("clear_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("clear_no_accept", busy, 0);
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("after_clear_in_ready", bus.in_ready, 1);
        begin
            int seen = 0;
            repeat (10) begin
                @(posedge clk); #1;
                if (bus.out_valid) seen++;
            end
            chk("clear_out_valid_never", seen, 0);
        end
        hist.delete();
        send_word(8'h00, 0, 0);

        send_word(8'hF0, 0, 0);
        send_word(8'hFF, 1, 0);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        hist.delete();

        for (int n = 0; n < 30; n++)
            send_word(W'($urandom), $urandom_range(0, 3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
